// File: rtl/lfsr_divider_if.sv
// Mapper-to-divider handshake: the mapper publishes the LFSR reset value dp and its done level,
// and the divider drives start back to request a re-map.
interface lfsr_divider_if;
  logic [8:0] dp;
  logic       done;
  logic       start;

  modport master (output dp, output done, input start);
  modport slave  (input dp, input done, output start);
endinterface

// File: rtl/lfsr_divider.sv
// LFSR-based programmable divider: reloads an 8-bit XNOR LFSR from the mapper seed and ticks at each terminal visit.
// Optional feature macro: LFSR_DIV_TICK_CNT_EN adds a saturating tick_count output.
module lfsr_divider #(
  parameter logic [7:0] TERM_STATE = 8'h00
) (
  input  logic          clock,
  input  logic          reset_n,
  lfsr_divider_if.slave map,
  input  logic          cfg_req,
  output logic          tick,
  output logic          div_out,
  output logic          cfg_valid,
  output logic          busy
`ifdef LFSR_DIV_TICK_CNT_EN
  ,
  output logic [15:0]   tick_count
`endif
);

  typedef enum logic [1:0] {
    WAIT_MAP = 2'd0,
    RUN      = 2'd1,
    REQ      = 2'd2
  } stateType;

  stateType   state;
  logic [7:0] sr;
  logic [8:0] seed;
  logic       stall;
  logic       doneQ;
  logic       doneRise;
  logic [7:0] srStep;

  assign doneRise = map.done & ~doneQ;
  assign srStep   = {sr[6:0], ~(sr[7] ^ sr[5] ^ sr[4] ^ sr[3])};

  // A load takes priority over periodic generation so the new seed starts cleanly with no tick;
  // otherwise the old seed keeps running through REQ and WAIT_MAP for a glitch-free retune.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= WAIT_MAP;
      sr         <= 8'h00;
      seed       <= 9'h000;
      stall      <= 1'b0;
      doneQ      <= 1'b0;
      tick       <= 1'b0;
      div_out    <= 1'b0;
      cfg_valid  <= 1'b0;
      busy       <= 1'b1;
      map.start  <= 1'b0;
`ifdef LFSR_DIV_TICK_CNT_EN
      tick_count <= 16'h0000;
`endif
    end else begin
      doneQ <= map.done;
      tick  <= 1'b0;
      if (state == WAIT_MAP && doneRise) begin
        seed      <= map.dp;
        sr        <= map.dp[8:1];
        stall     <= 1'b0;
        cfg_valid <= 1'b1;
        state     <= cfg_req ? REQ : RUN;
        map.start <= cfg_req;
        busy      <= cfg_req;
`ifdef LFSR_DIV_TICK_CNT_EN
        tick_count <= 16'h0000;
`endif
      end else begin
        if (cfg_valid) begin
          if (sr != TERM_STATE) begin
            sr <= srStep;
          end else if (seed[0] && !stall) begin
            stall <= 1'b1;
          end else begin
            sr      <= seed[8:1];
            stall   <= 1'b0;
            tick    <= 1'b1;
            div_out <= ~div_out;
`ifdef LFSR_DIV_TICK_CNT_EN
            if (tick_count != 16'hFFFF) tick_count <= tick_count + 16'd1;
`endif
          end
        end
        case (state)
          RUN: begin
            if (cfg_req) begin
              state     <= REQ;
              map.start <= 1'b1;
              busy      <= 1'b1;
            end
          end
          REQ: begin
            if (!map.done) begin
              state     <= WAIT_MAP;
              map.start <= 1'b0;
            end
          end
          WAIT_MAP: ;
          default: begin
            state     <= WAIT_MAP;
            map.start <= 1'b0;
            busy      <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_divider.sv
// Directed bench for lfsr_divider: one instance with the default terminal state, one with TERM_STATE=8'h0F.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_lfsr_divider;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       cfg_req;
  logic [8:0] dp;
  logic       done;

  logic tickA, divA, validA, busyA;
  logic tickB, divB, validB, busyB;
`ifdef LFSR_DIV_TICK_CNT_EN
  logic [15:0] countA, countB;
`endif

  int checks = 0;
  int errors = 0;
  int tA, fA, tB, fB;

  lfsr_divider_if ifA ();
  lfsr_divider_if ifB ();

  assign ifA.dp   = dp;
  assign ifA.done = done;
  assign ifB.dp   = dp;
  assign ifB.done = done;

  lfsr_divider dutA (
    .clock     (clock),
    .reset_n   (reset_n),
    .map       (ifA),
    .cfg_req   (cfg_req),
    .tick      (tickA),
    .div_out   (divA),
    .cfg_valid (validA),
    .busy      (busyA)
`ifdef LFSR_DIV_TICK_CNT_EN
    ,
    .tick_count(countA)
`endif
  );

  lfsr_divider #(.TERM_STATE(8'h0F)) dutB (
    .clock     (clock),
    .reset_n   (reset_n),
    .map       (ifB),
    .cfg_req   (cfg_req),
    .tick      (tickB),
    .div_out   (divB),
    .cfg_valid (validB),
    .busy      (busyB)
`ifdef LFSR_DIV_TICK_CNT_EN
    ,
    .tick_count(countB)
`endif
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic req, input logic d, input logic [8:0] p);
    reset_n = r;
    cfg_req = req;
    done    = d;
    dp      = p;
    cycles(1);
  endtask

  // Counts ticks and div_out transitions of both instances over n cycles.
  task automatic countWindow(input int n);
    logic prevA, prevB;
    tA = 0; fA = 0; tB = 0; fB = 0;
    for (int i = 0; i < n; i++) begin
      prevA = divA;
      prevB = divB;
      cycles(1);
      if (tickA) tA++;
      if (tickB) tB++;
      if (divA != prevA) fA++;
      if (divB != prevB) fB++;
    end
  endtask

  // Full re-map from RUN: request, mapper drops done, then done rises with the new value.
  task automatic remapTo(input logic [8:0] p);
    applyStimulus(1'b1, 1'b1, 1'b1, dp);
    applyStimulus(1'b1, 1'b0, 1'b1, dp);
    applyStimulus(1'b1, 1'b0, 1'b0, p);
    applyStimulus(1'b1, 1'b0, 1'b1, p);
  endtask

  initial begin
    reset_n = 1'b0;
    cfg_req = 1'b0;
    done    = 1'b0;
    dp      = 9'h000;
    cycles(3);
    checkOutput("reset_start", ifA.start, 1'b0);
    checkOutput("reset_tick", tickA, 1'b0);
    checkOutput("reset_div", divA, 1'b0);
    checkOutput("reset_valid", validA, 1'b0);
    checkOutput("reset_busy", busyA, 1'b1);
    checkOutput("reset_busyB", busyB, 1'b1);

    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    checkOutput("frozen_valid", validA, 1'b0);
    checkOutput("frozen_tick", tickA, 1'b0);
    checkOutput("frozen_div", divA, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b1, 9'h000);
    checkOutput("load0_valid", validA, 1'b1);
    checkOutput("load0_busy", busyA, 1'b0);
    checkOutput("load0_notick", tickA, 1'b0);
    checkOutput("load0_validB", validB, 1'b1);
    countWindow(20);
    checkOutput("p1_ticks", tA, 20);
    checkOutput("p1_flips", fA, 20);
    checkOutput("termB_seed00_ticks", tB, 4);
    checkOutput("termB_seed00_flips", fB, 4);

    applyStimulus(1'b1, 1'b1, 1'b1, 9'h000);
    checkOutput("req_start", ifA.start, 1'b1);
    checkOutput("req_busy", busyA, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 9'h000);
    checkOutput("req_hold_start", ifA.start, 1'b1);
    countWindow(6);
    checkOutput("req_old_ticks", tA, 6);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h001);
    checkOutput("wait_start", ifA.start, 1'b0);
    checkOutput("wait_busy", busyA, 1'b1);
    countWindow(4);
    checkOutput("wait_old_ticks", tA, 4);
    applyStimulus(1'b1, 1'b0, 1'b1, 9'h001);
    checkOutput("load1_busy", busyA, 1'b0);
    checkOutput("load1_notick", tickA, 1'b0);
    countWindow(20);
    checkOutput("p2_ticks", tA, 10);
    checkOutput("p2_flips", fA, 10);

    remapTo(9'h002);
    countWindow(20);
    checkOutput("termB_dp002_ticks", tB, 5);
    remapTo(9'h003);
    countWindow(20);
    checkOutput("termB_dp003_ticks", tB, 4);

    applyStimulus(1'b1, 1'b1, 1'b1, 9'h003);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h003);
    applyStimulus(1'b1, 1'b1, 1'b1, 9'h000);
    checkOutput("same_valid", validA, 1'b1);
    checkOutput("same_start", ifA.start, 1'b1);
    checkOutput("same_busy", busyA, 1'b1);
    checkOutput("same_startB", ifB.start, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 9'h000);
    countWindow(10);
    checkOutput("same_new_ticks", tA, 10);
    checkOutput("same_still_start", ifA.start, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    checkOutput("same_drop_start", ifA.start, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 9'h001);
    checkOutput("run_busy", busyA, 1'b0);

    cycles(5);
    applyStimulus(1'b0, 1'b0, 1'b1, 9'h001);
    checkOutput("midreset_tick", tickA, 1'b0);
    checkOutput("midreset_div", divA, 1'b0);
    checkOutput("midreset_valid", validA, 1'b0);
    checkOutput("midreset_start", ifA.start, 1'b0);
    checkOutput("midreset_busy", busyA, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 9'h001);
    checkOutput("release_done_high_load", validA, 1'b1);
    countWindow(20);
    checkOutput("release_p2_ticks", tA, 10);

`ifdef LFSR_DIV_TICK_CNT_EN
    remapTo(9'h000);
    checkOutput("cnt_load_zero", countA, 16'h0000);
    cycles(300);
    checkOutput("cnt_300", countA, 16'd300);
    remapTo(9'h000);
    checkOutput("cnt_reload_zero", countA, 16'h0000);
    cycles(70000);
    checkOutput("cnt_saturate", countA, 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
